// File: rtl/wb_cmd_master.sv
// Command-to-Wishbone B4 master: one command in flight, issued as a single write or an incrementing read burst.
// Every ended beat (ack, err or timeout) returns exactly one response strobe.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_len_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        rsp_last_o,
    output logic        busy_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [2:0]  CTI_INCR    = 3'b010;
    localparam logic [2:0]  CTI_END     = 3'b111;
    // The edge that would push the wait count to TIMEOUT is the one that ends the beat.
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] to_cnt;
    logic [3:0]  beats_left;

    logic beat_err;
    logic beat_ack;
    logic beat_to;
    logic last_beat;

    function automatic logic [2:0] first_cti(input logic we, input logic [3:0] len);
        return (we || len == 4'd0) ? CTI_CLASSIC : CTI_INCR;
    endfunction

    function automatic logic [2:0] next_cti(input logic [3:0] left);
        return (left == 4'd1) ? CTI_END : CTI_INCR;
    endfunction

    // err outranks ack; either outranks a timeout landing on the same edge.
    assign beat_err  = wb_stb_o & wb_err_i;
    assign beat_ack  = wb_stb_o & wb_ack_i & ~wb_err_i;
    assign beat_to   = wb_stb_o & ~wb_ack_i & ~wb_err_i & (to_cnt == TO_LAST);
    assign last_beat = (beats_left == 4'd0);
    assign wb_bte_o  = 2'b00;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            cmd_ready_o   <= 1'b0;
            busy_o        <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_dat_o     <= 32'd0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_last_o    <= 1'b0;
            wb_adr_o      <= 32'd0;
            wb_dat_o      <= 32'd0;
            wb_sel_o      <= 4'd0;
            wb_we_o       <= 1'b0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_cti_o      <= CTI_CLASSIC;
            to_cnt        <= 16'd0;
            beats_left    <= 4'd0;
        end else begin
            rsp_valid_o   <= 1'b0;
            rsp_dat_o     <= 32'd0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_last_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        state       <= XFER;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        wb_adr_o    <= cmd_adr_i;
                        wb_dat_o    <= cmd_we_i ? cmd_dat_i : 32'd0;
                        wb_sel_o    <= cmd_sel_i;
                        wb_we_o     <= cmd_we_i;
                        wb_cti_o    <= first_cti(cmd_we_i, cmd_len_i);
                        beats_left  <= cmd_we_i ? 4'd0 : cmd_len_i;
                        to_cnt      <= 16'd0;
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end

                XFER: begin
                    if (beat_ack && !last_beat) begin
                        // Burst continues with no idle cycle between beats.
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= wb_we_o ? 32'd0 : wb_dat_i;
                        wb_adr_o    <= wb_adr_o + 32'd4;
                        wb_cti_o    <= next_cti(beats_left);
                        beats_left  <= beats_left - 4'd1;
                        to_cnt      <= 16'd0;
                    end else if (beat_ack || beat_err || beat_to) begin
                        state         <= IDLE;
                        cmd_ready_o   <= 1'b1;
                        busy_o        <= 1'b0;
                        wb_cyc_o      <= 1'b0;
                        wb_stb_o      <= 1'b0;
                        wb_cti_o      <= CTI_CLASSIC;
                        to_cnt        <= 16'd0;
                        rsp_valid_o   <= 1'b1;
                        rsp_dat_o     <= (beat_ack && !wb_we_o) ? wb_dat_i : 32'd0;
                        rsp_err_o     <= beat_err;
                        rsp_timeout_o <= beat_to;
                        rsp_last_o    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master (TIMEOUT=8): a scripted Wishbone slave, and a response scoreboard
// that holds expected responses against the responses the monitor collected.
module tb_wb_cmd_master;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        to;
        logic        last;
    } rsp_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_adr_i = 32'd0;
    logic [31:0] cmd_dat_i = 32'd0;
    logic [3:0]  cmd_sel_i = 4'd0;
    logic        cmd_we_i = 1'b0;
    logic [3:0]  cmd_len_i = 4'd0;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        rsp_last_o;
    logic        busy_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    int checks = 0;
    int failures = 0;

    rsp_t        exp_q[$];
    rsp_t        obs_q[$];
    logic [31:0] beat_adr[$];
    logic [2:0]  beat_cti[$];

    wb_cmd_master #(.TIMEOUT(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o), .rsp_last_o(rsp_last_o), .busy_o(busy_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(negedge wb_clk_i) begin
        if (rsp_valid_o)
            obs_q.push_back('{rsp_dat_o, rsp_err_o, rsp_timeout_o, rsp_last_o});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one command at a negedge once ready is seen; returns at the negedge after acceptance.
    task automatic issue_cmd(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input logic we, input logic [3:0] len);
        for (int i = 0; i < 20 && !cmd_ready_o; i++) @(negedge wb_clk_i);
        cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel; cmd_we_i = we; cmd_len_i = len;
        cmd_valid_i = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
    endtask

    // Slave model: each beat waits 'delay' cycles then acks (err on beat 'err_beat'); delay<0 never answers.
    task automatic run_slave(input int delay, input int err_beat, output int stb_cycles);
        int wait_cnt = 0;
        int beat = 0;
        stb_cycles = 0;
        beat_adr.delete();
        beat_cti.delete();
        for (int c = 0; c < 200; c++) begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0BAD_F00D;
            if (!wb_stb_o) break;
            stb_cycles++;
            if (delay >= 0 && wait_cnt == delay) begin
                beat_adr.push_back(wb_adr_o);
                beat_cti.push_back(wb_cti_o);
                if (beat == err_beat) wb_err_i = 1'b1;
                else begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = wb_adr_o ^ MAGIC;
                end
                beat++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            @(negedge wb_clk_i);
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", cmd_ready_o); end
        checks++; if ({wb_cyc_o, wb_stb_o, busy_o, rsp_valid_o} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {wb_cyc_o, wb_stb_o, busy_o, rsp_valid_o}); end
        checks++; if ({wb_adr_o, wb_dat_o, wb_cti_o, wb_bte_o} !== 69'd0) begin failures++; $display("FAIL reset_bus got=%h exp=0", {wb_adr_o, wb_dat_o, wb_cti_o, wb_bte_o}); end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready_o); end
    endtask

    task automatic test_single_write();
        int n;
        rsp_t e, o;
        issue_cmd(32'h100, 32'hDEADBEEF, 4'hF, 1'b1, 4'd5);
        exp_q.push_back('{32'd0, 1'b0, 1'b0, 1'b1});
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, busy_o, cmd_ready_o} !== 5'b11110) begin failures++; $display("FAIL wr_ctl got=%b exp=11110", {wb_cyc_o, wb_stb_o, wb_we_o, busy_o, cmd_ready_o}); end
        checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o} !== {32'h100, 32'hDEADBEEF, 4'hF, 3'b000}) begin failures++; $display("FAIL wr_bus got=%h_%h_%h_%h exp=100_deadbeef_f_0", wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o); end
        run_slave(2, -1, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL wr_stb_cycles got=%0d exp=3", n); end
        checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL wr_cyc_drop got=%b exp=0", wb_cyc_o); end
        repeat (2) @(negedge wb_clk_i); #1;
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL wr_rsp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL wr_rsp got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_read_burst();
        int n;
        rsp_t e, o;
        logic [31:0] ea[4];
        logic [2:0]  ec[4];
        ea = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
        ec = '{3'b010, 3'b010, 3'b010, 3'b111};
        issue_cmd(32'h2000, 32'h12345678, 4'hF, 1'b0, 4'd3);
        for (int i = 0; i < 4; i++) exp_q.push_back('{ea[i] ^ MAGIC, 1'b0, 1'b0, i == 3});
        checks++; if ({wb_we_o, wb_dat_o} !== 33'd0) begin failures++; $display("FAIL rd_we_dat got=%b_%h exp=0_0", wb_we_o, wb_dat_o); end
        run_slave(0, -1, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL rd_stb_cycles got=%0d exp=4", n); end
        checks++; if (beat_adr.size() != 4) begin failures++; $display("FAIL rd_beats got=%0d exp=4", beat_adr.size()); end
        for (int i = 0; i < 4 && i < beat_adr.size(); i++) begin
            checks++; if ({beat_adr[i], beat_cti[i]} !== {ea[i], ec[i]}) begin failures++; $display("FAIL rd_beat%0d got=%h/%b exp=%h/%b", i, beat_adr[i], beat_cti[i], ea[i], ec[i]); end
        end
        repeat (2) @(negedge wb_clk_i); #1;
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rd_rsp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL rd_rsp got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_error();
        int n;
        rsp_t e, o;
        issue_cmd(32'h3000, 32'h0, 4'h3, 1'b0, 4'd2);
        exp_q.push_back('{32'h3000 ^ MAGIC, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{32'd0, 1'b1, 1'b0, 1'b1});
        checks++; if (wb_sel_o !== 4'h3) begin failures++; $display("FAIL err_sel got=%h exp=3", wb_sel_o); end
        run_slave(0, 1, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL err_stb_cycles got=%0d exp=2", n); end
        checks++; if (beat_adr.size() != 2 || beat_adr[1] !== 32'h3004) begin failures++; $display("FAIL err_beats got=%0d exp=2 (second at 3004)", beat_adr.size()); end
        repeat (2) @(negedge wb_clk_i); #1;
        checks++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin failures++; $display("FAIL err_cyc got=%b exp=00", {wb_cyc_o, wb_stb_o}); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL err_rsp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL err_rsp got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_timeout();
        int n;
        rsp_t e, o;
        issue_cmd(32'h40, 32'h55AA55AA, 4'hF, 1'b1, 4'd0);
        exp_q.push_back('{32'd0, 1'b0, 1'b1, 1'b1});
        run_slave(-1, -1, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL to_stb_cycles got=%0d exp=8", n); end
        issue_cmd(32'h44, 32'h0, 4'hF, 1'b0, 4'd0);
        exp_q.push_back('{32'h44 ^ MAGIC, 1'b0, 1'b0, 1'b1});
        run_slave(7, -1, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL to_late_ack_cycles got=%0d exp=8", n); end
        checks++; if (beat_cti.size() != 1 || beat_cti[0] !== 3'b000) begin failures++; $display("FAIL to_late_ack_cti beats=%0d exp=1 with cti 000", beat_cti.size()); end
        repeat (2) @(negedge wb_clk_i); #1;
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL to_rsp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL to_rsp got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        int n;
        rsp_t e, o;
        issue_cmd(32'h6000, 32'h0, 4'hF, 1'b0, 4'd3);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o, busy_o, cmd_ready_o} !== 5'b0) begin failures++; $display("FAIL rst_mid_ctl got=%b exp=00000", {wb_cyc_o, wb_stb_o, rsp_valid_o, busy_o, cmd_ready_o}); end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge wb_clk_i); #1;
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rst_mid_no_rsp got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
        issue_cmd(32'h7000, 32'hCAFEF00D, 4'hC, 1'b1, 4'd0);
        exp_q.push_back('{32'd0, 1'b0, 1'b0, 1'b1});
        run_slave(1, -1, n);
        checks++; if (n !== 2 || beat_adr.size() != 1 || beat_adr[0] !== 32'h7000) begin failures++; $display("FAIL rst_mid_next_cmd cycles=%0d beats=%0d exp=2 cycles 1 beat at 7000", n, beat_adr.size()); end
        repeat (2) @(negedge wb_clk_i); #1;
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rst_mid_rsp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL rst_mid_rsp got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int n;
        rsp_t e, o;
        for (int i = 0; i < 20 && !cmd_ready_o; i++) @(negedge wb_clk_i);
        cmd_adr_i = 32'hFFFF_FFFC; cmd_dat_i = 32'h0; cmd_sel_i = 4'hF; cmd_we_i = 1'b0; cmd_len_i = 4'd1;
        cmd_valid_i = 1'b1;
        @(negedge wb_clk_i);
        cmd_adr_i = 32'h5000; cmd_len_i = 4'd0;
        exp_q.push_back('{32'hFFFF_FFFC ^ MAGIC, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{32'h0000_0000 ^ MAGIC, 1'b0, 1'b0, 1'b1});
        exp_q.push_back('{32'h5000 ^ MAGIC, 1'b0, 1'b0, 1'b1});
        checks++; if ({cmd_ready_o, busy_o} !== 2'b01) begin failures++; $display("FAIL b2b_busy got=%b exp=01", {cmd_ready_o, busy_o}); end
        run_slave(0, -1, n);
        checks++; if (beat_adr.size() != 2 || beat_adr[0] !== 32'hFFFF_FFFC || beat_adr[1] !== 32'h0) begin failures++; $display("FAIL b2b_wrap beats=%0d exp=2 at fffffffc,00000000", beat_adr.size()); end
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_at_rsp got=%b exp=1", cmd_ready_o); end
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        checks++; if ({wb_stb_o, wb_adr_o, wb_cti_o} !== {1'b1, 32'h5000, 3'b000}) begin failures++; $display("FAIL b2b_second got=%b/%h/%b exp=1/00005000/000", wb_stb_o, wb_adr_o, wb_cti_o); end
        run_slave(0, -1, n);
        checks++; if (n !== 1) begin failures++; $display("FAIL b2b_second_cycles got=%0d exp=1", n); end
        repeat (2) @(negedge wb_clk_i); #1;
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_rsp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL b2b_rsp got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_error();
        test_timeout();
        test_reset_mid_burst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: wb_clk_i and wb_rst_i.
REQ-002 The block SHALL have one parameter: TIMEOUT, default 255, the cycles a beat may wait for ack/err (legal 1..65535).
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  async active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_adr_i  in  32  start byte address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte selects
- cmd_we_i  in  1  1=write, 0=read
- cmd_len_i  in  4  read beats minus 1 (ignored for writes)
- rsp_valid_o  out  1  one-cycle response strobe per beat
- rsp_dat_o  out  32  read data (0 for writes, errors, timeouts)
- rsp_err_o  out  1  beat ended by wb_err_i
- rsp_timeout_o  out  1  beat ended by timeout
- rsp_last_o  out  1  final response of the command
- busy_o  out  1  command in progress
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte selects
- wb_we_o  out  1  Wishbone write enable
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_cti_o  out  3  cycle type identifier
- wb_bte_o  out  2  burst type, constant 2'b00
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

Function
REQ-004 The state machine SHALL have states IDLE and XFER; cmd_ready_o SHALL be 1 only in IDLE and busy_o SHALL be 1 only in XFER.
REQ-005 On cmd_valid_i&cmd_ready_o the block SHALL latch the command and enter XFER; wb_cyc_o/wb_stb_o SHALL be 1 from the next cycle.
REQ-006 While busy, cmd_valid_i SHALL be ignored; no command is queued.
REQ-007 In XFER: wb_we_o=cmd_we_i, wb_sel_o=cmd_sel_i, wb_dat_o=cmd_dat_i for writes and 0 for reads, all held stable until the beat ends.
REQ-008 Beat count SHALL be cmd_len_i+1 for reads and 1 for writes.
REQ-009 wb_cti_o SHALL be 3'b000 for one-beat commands; for multi-beat reads 3'b010 on every beat except the last, which SHALL be 3'b111.
REQ-010 A beat SHALL end at the edge sampling wb_ack_i or wb_err_i with wb_stb_o=1; wb_err_i SHALL take priority when both are high.
REQ-011 On ack of a non-last beat: wb_adr_o+=4 (mod 2^32), wb_stb_o stays 1, next beat starts the following cycle without idle.
REQ-012 On ack of the last beat, err, or timeout: wb_cyc_o/wb_stb_o SHALL deassert at that edge and the state SHALL return to IDLE.
REQ-013 Each ended beat SHALL produce rsp_valid_o=1 for exactly the cycle after the ending edge, with rsp_dat_o=wb_dat_i (read ack) else 0.
REQ-014 rsp_last_o SHALL be 1 on the response of the last beat, an err, or a timeout; rsp_err_o/rsp_timeout_o SHALL be mutually exclusive.
REQ-015 The timeout counter SHALL clear at each beat start and count cycles with wb_stb_o=1 and no ack/err; at count==TIMEOUT the beat SHALL end as timeout.
REQ-016 ack/err arriving in the same cycle the count reaches TIMEOUT SHALL win over timeout.
REQ-017 A new command SHALL be accepted no earlier than the cycle the last response is presented (back-to-back rate: one idle bus cycle between commands).

Reset
REQ-018 Asserting wb_rst_i SHALL immediately force IDLE and all outputs to 0 except cmd_ready_o, which SHALL be 0 while reset is asserted and 1 from the first cycle after release.
REQ-019 Reset during XFER SHALL abort the cycle with no response generated.

Verification
REQ-020 Single write adr=0x100, dat=0xDEADBEEF, sel=0xF, ack after 2 wait cycles -> cyc/stb high 3 cycles, cti=000, one rsp with last=1, err=0, dat=0.
REQ-021 Read len=3 at 0x2000, ack every cycle -> addresses 0x2000,0x2004,0x2008,0x200C, cti 010,010,010,111, four rsp_valid pulses, last only on fourth.
REQ-022 Read len=2 with err on second beat -> two responses, second err=1, last=1, dat=0; cyc drops; third beat never issued.
REQ-023 TIMEOUT=8, slave never responds -> stb high exactly 8 cycles, rsp timeout=1, last=1; ack arriving on cycle 8 instead -> normal ack response.
REQ-024 wb_rst_i pulsed mid-burst -> cyc/stb/rsp_valid 0 immediately, no response, next command after release completes normally.
REQ-025 cmd_valid_i held during XFER with altered address -> ignored; accepted only when cmd_ready_o returns to 1; address 0xFFFFFFFC burst wraps to 0x00000000.
